// File: rtl/nor_mis_sweep.sv
// ============================================================================
// Module   : nor_mis_sweep
// Purpose  : Sweeps input-edge skew into a NOR2 merge of two inverter chains
//            and reports the synchronized output value and toggle count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_mis_sweep #(
   parameter int DEPTH     = 11,
   parameter int OUT_DEPTH = 6,
   parameter int CNT_W     = 8,
   parameter int SETTLE    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] skew_lo,
   input  logic [CNT_W-1:0] skew_hi,
   input  logic [CNT_W-1:0] skew_step,
   input  logic             lead_b,
   input  logic             fall_mode,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             sample_valid,
   output logic [CNT_W-1:0] sample_skew,
   output logic             sample_out,
   output logic [CNT_W-1:0] sample_toggles
);

   localparam logic [2:0] c_idle    = 3'd0;
   localparam logic [2:0] c_preset  = 3'd1;
   localparam logic [2:0] c_launch1 = 3'd2;
   localparam logic [2:0] c_gap     = 3'd3;
   localparam logic [2:0] c_launch2 = 3'd4;
   localparam logic [2:0] c_observe = 3'd5;
   localparam logic [2:0] c_report  = 3'd6;

   localparam logic [CNT_W-1:0] c_settle_m1 = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] c_tog_max   = {CNT_W{1'b1}};

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic             r_drv_a;
   logic             r_drv_b;
   logic             r_sync1;
   logic             r_myout_s;
   logic             r_myout_p;
   logic [CNT_W-1:0] r_skew;
   logic [CNT_W-1:0] r_hi;
   logic [CNT_W-1:0] r_step;
   logic             r_lead_b;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_tog;
   logic [CNT_W-1:0] w_tog_nxt;
   logic             r_done;
   logic             r_cfg_err;
   logic [CNT_W-1:0] r_sample_skew;
   logic             r_sample_out;
   logic [CNT_W-1:0] r_sample_tog;
   logic [CNT_W:0]   w_sum;
   logic             w_last;
   logic             w_counting;
   logic             w_myout;

   function automatic logic nor2(input logic a, input logic b);
      return ~(a | b);
   endfunction

   // Each chain stage is a NOR2 with its second input tied low.
   always_comb begin : b_chains
      logic v_a;
      logic v_b;
      logic v_o;
      v_a = r_drv_a;
      v_b = r_drv_b;
      for (int i = 0; i < DEPTH; i++) begin
         v_a = nor2(v_a, 1'b0);
         v_b = nor2(v_b, 1'b0);
      end
      v_o = nor2(v_a, v_b);
      for (int i = 0; i < OUT_DEPTH; i++) begin
         v_o = nor2(v_o, 1'b0);
      end
      w_myout = v_o;
   end

   assign w_sum      = {1'b0, r_skew} + {1'b0, r_step};
   assign w_last     = (w_sum > {1'b0, r_hi});
   assign w_counting = (r_state == c_launch1) || (r_state == c_gap) ||
                       (r_state == c_launch2) || (r_state == c_observe);
   assign w_tog_nxt  = ((r_myout_s != r_myout_p) && (r_tog != c_tog_max)) ?
                       r_tog + 1'b1 : r_tog;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:    if (start && (skew_lo <= skew_hi)) w_state_nxt = c_preset;
         c_preset:  if (r_cnt == '0) w_state_nxt = c_launch1;
         c_launch1: begin
            if (r_skew == '0)                  w_state_nxt = c_observe;
            else if (r_skew == CNT_W'(1))      w_state_nxt = c_launch2;
            else                               w_state_nxt = c_gap;
         end
         c_gap:     if (r_cnt == '0) w_state_nxt = c_launch2;
         c_launch2: w_state_nxt = c_observe;
         c_observe: if (r_cnt == '0) w_state_nxt = c_report;
         c_report:  w_state_nxt = w_last ? c_idle : c_preset;
         default:   w_state_nxt = c_idle;
      endcase
   end

   always_comb begin
      busy         = (r_state != c_idle);
      sample_valid = (r_state == c_report);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drv_a       <= 1'b0;
         r_drv_b       <= 1'b0;
         r_sync1       <= 1'b0;
         r_myout_s     <= 1'b0;
         r_myout_p     <= 1'b0;
         r_skew        <= '0;
         r_hi          <= '0;
         r_step        <= '0;
         r_lead_b      <= 1'b0;
         r_fall        <= 1'b0;
         r_cnt         <= '0;
         r_tog         <= '0;
         r_done        <= 1'b0;
         r_cfg_err     <= 1'b0;
         r_sample_skew <= '0;
         r_sample_out  <= 1'b0;
         r_sample_tog  <= '0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         r_sync1   <= w_myout;
         r_myout_s <= r_sync1;
         r_myout_p <= r_myout_s;

         if ((r_state == c_idle) && start) begin
            if (skew_lo > skew_hi) begin
               r_cfg_err <= 1'b1;
            end else begin
               r_skew   <= skew_lo;
               r_hi     <= skew_hi;
               r_step   <= (skew_step == '0) ? CNT_W'(1) : skew_step;
               r_lead_b <= lead_b;
               r_fall   <= fall_mode;
            end
         end

         // Duration counter is reloaded on every state change and runs down to 0.
         if (w_state_nxt != r_state) begin
            case (w_state_nxt)
               c_preset:  r_cnt <= c_settle_m1;
               c_gap:     r_cnt <= r_skew - CNT_W'(2);
               c_observe: r_cnt <= c_settle_m1;
               default:   r_cnt <= '0;
            endcase
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end

         case (r_state)
            c_preset: begin
               r_drv_a <= r_fall;
               r_drv_b <= r_fall;
               r_tog   <= '0;
            end
            c_launch1: begin
               if (r_skew == '0) begin
                  r_drv_a <= ~r_drv_a;
                  r_drv_b <= ~r_drv_b;
               end else if (r_lead_b) begin
                  r_drv_b <= ~r_drv_b;
               end else begin
                  r_drv_a <= ~r_drv_a;
               end
            end
            c_launch2: begin
               if (r_lead_b) r_drv_a <= ~r_drv_a;
               else          r_drv_b <= ~r_drv_b;
            end
            default: ;
         endcase

         if (w_counting) r_tog <= w_tog_nxt;

         if ((r_state == c_observe) && (r_cnt == '0)) begin
            r_sample_skew <= r_skew;
            r_sample_out  <= r_myout_s;
            r_sample_tog  <= w_tog_nxt;
         end

         if (r_state == c_report) begin
            if (w_last) r_done <= 1'b1;
            else        r_skew <= w_sum[CNT_W-1:0];
         end
      end
   end

   assign done           = r_done;
   assign cfg_err        = r_cfg_err;
   assign sample_skew    = r_sample_skew;
   assign sample_out     = r_sample_out;
   assign sample_toggles = r_sample_tog;

endmodule

`default_nettype wire

// File: tb/tb_nor_mis_sweep.sv
// ============================================================================
// Module   : tb_nor_mis_sweep
// Purpose  : Directed sweeps with a queued scoreboard checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nor_mis_sweep;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] skew_lo = '0;
   logic [CNT_W-1:0] skew_hi = '0;
   logic [CNT_W-1:0] skew_step = '0;
   logic             lead_b = 1'b0;
   logic             fall_mode = 1'b0;
   logic             busy;
   logic             done;
   logic             cfg_err;
   logic             sample_valid;
   logic [CNT_W-1:0] sample_skew;
   logic             sample_out;
   logic [CNT_W-1:0] sample_toggles;

   nor_mis_sweep #(.DEPTH(11), .OUT_DEPTH(6), .CNT_W(CNT_W), .SETTLE(16)) dut (
      .clk(clk), .rst(rst), .start(start),
      .skew_lo(skew_lo), .skew_hi(skew_hi), .skew_step(skew_step),
      .lead_b(lead_b), .fall_mode(fall_mode),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .sample_valid(sample_valid), .sample_skew(sample_skew),
      .sample_out(sample_out), .sample_toggles(sample_toggles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int skew;
      int out;
      int tog;
      int lead;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_valid = 0;
   int   n_done = 0;
   int   n_cfg = 0;
   int   cyc = 0;
   int   last_valid = -100;
   int   ea = 0;
   int   eb = 0;
   logic pa = 1'b0;
   logic pb = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int skew, input int out, input int tog, input int lead);
      exp_t e;
      e.skew = skew; e.out = out; e.tog = tog; e.lead = lead;
      exp_q.push_back(e);
   endtask

   task automatic go(input int lo, input int hi, input int step, input logic lb, input logic fm);
      @(negedge clk);
      skew_lo   = CNT_W'(lo);
      skew_hi   = CNT_W'(hi);
      skew_step = CNT_W'(step);
      lead_b    = lb;
      fall_mode = fm;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   // Monitor: logs launch edges, pops expected samples, checks done timing.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (dut.r_drv_a != pa) ea = cyc;
      if (dut.r_drv_b != pb) eb = cyc;
      pa = dut.r_drv_a;
      pb = dut.r_drv_b;
      if (sample_valid) begin
         n_valid++;
         last_valid = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_sample", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sample_skew", int'(sample_skew), e.skew);
            chk("sample_out", int'(sample_out), e.out);
            chk("sample_toggles", int'(sample_toggles), e.tog);
            chk("edge_separation", e.lead != 0 ? ea - eb : eb - ea, e.skew);
         end
      end
      if (done) begin
         n_done++;
         chk("done_after_report", cyc - last_valid, 1);
      end
      if (cfg_err) n_cfg++;
   end

   initial begin
      int nv;
      int nd;
      int nc;
      int busy_seen;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_cfg_err", int'(cfg_err), 0);
      chk("reset_valid", int'(sample_valid), 0);
      chk("reset_skew", int'(sample_skew), 0);
      chk("reset_out", int'(sample_out), 0);
      chk("reset_toggles", int'(sample_toggles), 0);

      // Single point, rising inputs, A leads by 3
      push(3, 1, 1, 0);
      go(3, 3, 1, 1'b0, 1'b0);
      wait_done(300);
      chk("t1_queue_empty", exp_q.size(), 0);

      // Falling inputs, 0..4 step 2
      push(0, 0, 1, 0); push(2, 0, 1, 0); push(4, 0, 1, 0);
      go(0, 4, 2, 1'b0, 1'b1);
      wait_done(600);
      chk("t2_queue_empty", exp_q.size(), 0);

      // B leads by 5
      push(5, 1, 1, 1);
      go(5, 5, 1, 1'b1, 1'b0);
      wait_done(300);
      chk("t3_queue_empty", exp_q.size(), 0);

      // Inverted range
      nv = n_valid; nd = n_done; nc = n_cfg;
      go(5, 2, 1, 1'b0, 1'b0);
      busy_seen = 0;
      repeat (40) begin
         if (busy) busy_seen = 1;
         @(negedge clk);
      end
      chk("cfg_err_pulses", n_cfg - nc, 1);
      chk("cfg_busy_seen", busy_seen, 0);
      chk("cfg_no_valid", n_valid - nv, 0);
      chk("cfg_no_done", n_done - nd, 0);

      // Near top of range: no wrap past 255
      nv = n_valid;
      push(250, 1, 1, 0);
      go(250, 255, 10, 1'b0, 1'b0);
      wait_done(1000);
      repeat (60) @(negedge clk);
      chk("t5_one_sample", n_valid - nv, 1);
      chk("t5_queue_empty", exp_q.size(), 0);

      // Reset in GAP
      go(8, 8, 1, 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      chk("gap_busy_before", int'(busy), 1);
      chk("gap_drv_a_before", int'(dut.r_drv_a), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_drv_a", int'(dut.r_drv_a), 0);
      chk("rst_drv_b", int'(dut.r_drv_b), 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      nv = n_valid; nd = n_done; nc = n_cfg;
      repeat (2) @(negedge clk);
      chk("post_rst_quiet", (n_valid - nv) + (n_done - nd) + (n_cfg - nc), 0);
      push(2, 1, 1, 0);
      go(2, 2, 1, 1'b0, 1'b0);
      wait_done(300);
      chk("post_rst_one_sample", n_valid - nv, 1);
      chk("post_rst_one_done", n_done - nd, 1);

      // Step 0 with a stray start while busy
      push(1, 1, 1, 0); push(2, 1, 1, 0); push(3, 1, 1, 0);
      go(1, 3, 0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      go(9, 9, 1, 1'b1, 1'b1);
      wait_done(600);
      repeat (40) @(negedge clk);
      chk("t7_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
